// File: rtl/decode_stage.sv
// RV32 decode stage: combinational decode on the input side feeding a two-entry
// elastic buffer (output register plus skid register) with valid/ready on both sides.
module decode_stage #(
  parameter int NREGS = 32,
  parameter bit M_EXT = 1'b0,
  localparam int RW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [31:0]   instruction_i,
  input  logic [31:0]   pc_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [31:0]   pc_o,
  output logic [6:0]    opcode_o,
  output logic [2:0]    funct3_o,
  output logic [6:0]    funct7_o,
  output logic [RW-1:0] rs1_o,
  output logic [RW-1:0] rs2_o,
  output logic [RW-1:0] rd_o,
  output logic [31:0]   imm_o,
  output logic [2:0]    fmt_o,
  output logic          rs1_used_o,
  output logic          rs2_used_o,
  output logic          rd_we_o,
  output logic          illegal_o
);

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                         FMT_U = 3'd4, FMT_J = 3'd5, FMT_X = 3'd7;

  typedef struct packed {
    logic [31:0]   pc;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd;
    logic [31:0]   imm;
    logic [2:0]    fmt;
    logic          rs1_used;
    logic          rs2_used;
    logic          rd_we;
    logic          illegal;
  } dec_t;

  dec_t dec_next;
  dec_t out_reg, skd_reg;
  logic out_valid_reg, skd_valid_reg;

  logic [31:0] ins;
  logic [6:0]  op, f7;
  logic [2:0]  f3, fmt_raw;
  logic        legal, is_sys, r1u, r2u, rdw;

  assign ins = instruction_i;
  assign op  = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  always_comb begin
    legal   = 1'b1;
    is_sys  = 1'b0;
    fmt_raw = FMT_X;
    case (op)
      7'b0110011: begin
        fmt_raw = FMT_R;
        legal   = (f7 == 7'b0000000) ||
                  (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) ||
                  (f7 == 7'b0000001 && M_EXT);
      end
      7'b0010011: begin
        fmt_raw = FMT_I;
        legal   = !(f3 == 3'd1 && f7 != 7'b0000000) &&
                  !(f3 == 3'd5 && f7 != 7'b0000000 && f7 != 7'b0100000);
      end
      7'b0000011: begin
        fmt_raw = FMT_I;
        legal   = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      end
      7'b1100111: begin
        fmt_raw = FMT_I;
        legal   = (f3 == 3'd0);
      end
      7'b1110011: begin
        fmt_raw = FMT_I;
        is_sys  = 1'b1;
      end
      7'b0100011: begin
        fmt_raw = FMT_S;
        legal   = (f3 < 3'd3);
      end
      7'b1100011: begin
        fmt_raw = FMT_B;
        legal   = !(f3 == 3'd2 || f3 == 3'd3);
      end
      7'b0110111, 7'b0010111: fmt_raw = FMT_U;
      7'b1101111:             fmt_raw = FMT_J;
      default:                legal = 1'b0;
    endcase

    r1u = legal && !is_sys && (fmt_raw == FMT_R || fmt_raw == FMT_I ||
                               fmt_raw == FMT_S || fmt_raw == FMT_B);
    r2u = legal && (fmt_raw == FMT_R || fmt_raw == FMT_S || fmt_raw == FMT_B);
    rdw = legal && !is_sys && (ins[11:7] != 5'd0) &&
          (fmt_raw == FMT_R || fmt_raw == FMT_I || fmt_raw == FMT_U || fmt_raw == FMT_J);

    // A reduced register file cannot address x16..x31 in any field actually used.
    if (NREGS < 32 && ((r1u && ins[19]) || (r2u && ins[24]) || (rdw && ins[11]))) begin
      legal = 1'b0;
    end

    dec_next        = '0;
    dec_next.pc     = pc_i;
    dec_next.opcode = op;
    dec_next.funct3 = f3;
    dec_next.funct7 = f7;
    dec_next.rs1    = ins[15 +: RW];
    dec_next.rs2    = ins[20 +: RW];
    dec_next.rd     = ins[7 +: RW];
    dec_next.illegal = !legal;
    if (legal) begin
      dec_next.fmt      = fmt_raw;
      dec_next.rs1_used = r1u;
      dec_next.rs2_used = r2u;
      dec_next.rd_we    = rdw;
      case (fmt_raw)
        FMT_I:   dec_next.imm = {{20{ins[31]}}, ins[31:20]};
        FMT_S:   dec_next.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        FMT_B:   dec_next.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        FMT_U:   dec_next.imm = {ins[31:12], 12'b0};
        FMT_J:   dec_next.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        default: dec_next.imm = 32'd0;
      endcase
    end else begin
      dec_next.fmt = FMT_X;
    end
  end

  // OUT refills from SKD first; a new beat can only land in SKD while OUT is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg       <= '0;
      skd_reg       <= '0;
      out_valid_reg <= 1'b0;
      skd_valid_reg <= 1'b0;
    end else if (flush_i) begin
      out_valid_reg <= 1'b0;
      skd_valid_reg <= 1'b0;
    end else if (!out_valid_reg || ready_i) begin
      if (skd_valid_reg) begin
        out_reg       <= skd_reg;
        out_valid_reg <= 1'b1;
        skd_valid_reg <= 1'b0;
      end else if (valid_i) begin
        out_reg       <= dec_next;
        out_valid_reg <= 1'b1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (valid_i && !skd_valid_reg) begin
      skd_reg       <= dec_next;
      skd_valid_reg <= 1'b1;
    end
  end

  assign ready_o    = !skd_valid_reg;
  assign valid_o    = out_valid_reg;
  assign pc_o       = out_reg.pc;
  assign opcode_o   = out_reg.opcode;
  assign funct3_o   = out_reg.funct3;
  assign funct7_o   = out_reg.funct7;
  assign rs1_o      = out_reg.rs1;
  assign rs2_o      = out_reg.rs2;
  assign rd_o       = out_reg.rd;
  assign imm_o      = out_reg.imm;
  assign fmt_o      = out_reg.fmt;
  assign rs1_used_o = out_reg.rs1_used;
  assign rs2_used_o = out_reg.rs2_used;
  assign rd_we_o    = out_reg.rd_we;
  assign illegal_o  = out_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: three configurations (RV32I, RV32I+M, RV32E) share one
// input stream; a queue-based occupancy model and an arithmetic decode model check them.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        rs1_used;
    logic        rs2_used;
    logic        rd_we;
    logic        illegal;
  } beat_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } txn_t;

  logic clk = 1'b0, rst = 1'b1, flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic [31:0] instruction_i = '0, pc_i = '0;
  always #5 clk = ~clk;

  logic        valid_a, ready_a, valid_m, ready_m, valid_e, ready_e;
  logic [31:0] pc_a, pc_m, pc_e, imm_a, imm_m, imm_e;
  logic [6:0]  opc_a, opc_m, opc_e, f7_a, f7_m, f7_e;
  logic [2:0]  f3_a, f3_m, f3_e, fmt_a, fmt_m, fmt_e;
  logic [4:0]  rs1_a, rs2_a, rd_a, rs1_m, rs2_m, rd_m;
  logic [3:0]  rs1_e, rs2_e, rd_e;
  logic        u1_a, u2_a, we_a, il_a, u1_m, u2_m, we_m, il_m, u1_e, u2_e, we_e, il_e;

  decode_stage #(.NREGS(32), .M_EXT(1'b0)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_a),
    .instruction_i(instruction_i), .pc_i(pc_i), .valid_o(valid_a), .ready_i(ready_i),
    .pc_o(pc_a), .opcode_o(opc_a), .funct3_o(f3_a), .funct7_o(f7_a), .rs1_o(rs1_a),
    .rs2_o(rs2_a), .rd_o(rd_a), .imm_o(imm_a), .fmt_o(fmt_a), .rs1_used_o(u1_a),
    .rs2_used_o(u2_a), .rd_we_o(we_a), .illegal_o(il_a));

  decode_stage #(.NREGS(32), .M_EXT(1'b1)) dut_m (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_m),
    .instruction_i(instruction_i), .pc_i(pc_i), .valid_o(valid_m), .ready_i(ready_i),
    .pc_o(pc_m), .opcode_o(opc_m), .funct3_o(f3_m), .funct7_o(f7_m), .rs1_o(rs1_m),
    .rs2_o(rs2_m), .rd_o(rd_m), .imm_o(imm_m), .fmt_o(fmt_m), .rs1_used_o(u1_m),
    .rs2_used_o(u2_m), .rd_we_o(we_m), .illegal_o(il_m));

  decode_stage #(.NREGS(16), .M_EXT(1'b0)) dut_e (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_e),
    .instruction_i(instruction_i), .pc_i(pc_i), .valid_o(valid_e), .ready_i(ready_i),
    .pc_o(pc_e), .opcode_o(opc_e), .funct3_o(f3_e), .funct7_o(f7_e), .rs1_o(rs1_e),
    .rs2_o(rs2_e), .rd_o(rd_e), .imm_o(imm_e), .fmt_o(fmt_e), .rs1_used_o(u1_e),
    .rs2_used_o(u2_e), .rd_we_o(we_e), .illegal_o(il_e));

  beat_t obs_a, obs_m, obs_e;
  assign obs_a = {pc_a, opc_a, f3_a, f7_a, rs1_a, rs2_a, rd_a, imm_a, fmt_a, u1_a, u2_a, we_a, il_a};
  assign obs_m = {pc_m, opc_m, f3_m, f7_m, rs1_m, rs2_m, rd_m, imm_m, fmt_m, u1_m, u2_m, we_m, il_m};
  assign obs_e = {pc_e, opc_e, f3_e, f7_e, 1'b0, rs1_e, 1'b0, rs2_e, 1'b0, rd_e, imm_e, fmt_e,
                  u1_e, u2_e, we_e, il_e};

  int compared = 0;
  int mismatched = 0;
  txn_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input beat_t obs, input beat_t exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decode model from the ISA rules: format by opcode, legality by field rules.
  function automatic beat_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                    input int nregs, input bit mext);
    beat_t b;
    logic [6:0] op, f7;
    logic [2:0] f3;
    int fmt, t;
    bit legal, sys, r1u, r2u, rdw;
    logic signed [12:0] bimm;
    logic signed [20:0] jimm;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    legal = 1'b1; sys = 1'b0; fmt = 7;
    case (op)
      7'h33: begin fmt = 0; legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (f7 == 1 && mext); end
      7'h13: begin fmt = 1; legal = !(f3 == 1 && f7 != 0) && !(f3 == 5 && f7 != 0 && f7 != 7'h20); end
      7'h03: begin fmt = 1; legal = !(f3 inside {3'd3, 3'd6, 3'd7}); end
      7'h67: begin fmt = 1; legal = (f3 == 0); end
      7'h73: begin fmt = 1; sys = 1'b1; end
      7'h23: begin fmt = 2; legal = (f3 < 3); end
      7'h63: begin fmt = 3; legal = !(f3 inside {3'd2, 3'd3}); end
      7'h37, 7'h17: fmt = 4;
      7'h6f: fmt = 5;
      default: legal = 1'b0;
    endcase
    r1u = (fmt <= 3) && !sys;
    r2u = (fmt == 0 || fmt == 2 || fmt == 3);
    rdw = (fmt == 0 || fmt == 1 || fmt == 4 || fmt == 5) && !sys && ins[11:7] != 0;
    if (nregs == 16 && ((r1u && ins[19]) || (r2u && ins[24]) || (rdw && ins[11]))) legal = 1'b0;
    b = '0;
    b.pc = pc; b.opcode = op; b.funct3 = f3; b.funct7 = f7;
    b.rs1 = 5'(int'(ins[19:15]) % nregs);
    b.rs2 = 5'(int'(ins[24:20]) % nregs);
    b.rd  = 5'(int'(ins[11:7]) % nregs);
    b.illegal = !legal;
    if (!legal) begin
      b.fmt = 3'd7;
    end else begin
      b.fmt = 3'(fmt);
      b.rs1_used = r1u; b.rs2_used = r2u; b.rd_we = rdw;
      case (fmt)
        1: b.imm = 32'($signed(ins) >>> 20);
        2: begin t = $signed(ins) >>> 25; b.imm = 32'(t * 32 + int'(ins[11:7])); end
        3: begin bimm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; t = bimm; b.imm = 32'(t); end
        4: b.imm = ins & 32'hFFFFF000;
        5: begin jimm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; t = jimm; b.imm = 32'(t); end
        default: b.imm = 32'd0;
      endcase
    end
    return b;
  endfunction

  // One cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl, input logic rs, output logic acc);
    logic exp_v, exp_r;
    exp_v = (q.size() > 0);
    exp_r = (q.size() < 2);
    chk("valid_o", {29'b0, valid_a, valid_m, valid_e}, {29'b0, {3{exp_v}}});
    chk("ready_o", {29'b0, ready_a, ready_m, ready_e}, {29'b0, {3{exp_r}}});
    if (exp_v) begin
      chkb("beat_rv32i", obs_a, ref_dec(q[0].ins, q[0].pc, 32, 1'b0));
      chkb("beat_rv32im", obs_m, ref_dec(q[0].ins, q[0].pc, 32, 1'b1));
      chkb("beat_rv32e", obs_e, ref_dec(q[0].ins, q[0].pc, 16, 1'b0));
    end
    valid_i = v; instruction_i = ins; pc_i = pc; ready_i = rdy; flush_i = fl; rst = rs;
    acc = v && exp_r && !fl && !rs;
    if (fl || rs) begin
      q.delete();
    end else begin
      if (exp_v && rdy) void'(q.pop_front());
      if (acc) q.push_back({ins, pc});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    logic [6:0] op;
    w = $urandom();
    case ($urandom_range(0, 11))
      0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h67;
      4: op = 7'h73;  5: op = 7'h23;  6: op = 7'h63;  7: op = 7'h37;
      8: op = 7'h17;  9: op = 7'h6f;  10: op = 7'h0f; default: op = w[6:0];
    endcase
    w[6:0] = op;
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  logic acc;
  logic [31:0] dir_ins [9];
  logic [31:0] stream [8];
  int sent, cyc;

  initial begin
    dir_ins = '{32'h00000013, 32'h0070A423, 32'h00F0C403, 32'hFE000EE3, 32'h123452B7,
                32'hFFFFFFFF, 32'h00003003, 32'h02000033, 32'h00000833};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_o", {31'b0, valid_a}, 32'd0);
    chk("rst_ready_o", {31'b0, ready_a}, 32'd1);
    chkb("rst_outputs_zero", obs_a, '0);

    // Directed decodes with spot checks on known ISA values.
    foreach (dir_ins[i]) begin
      step(1'b1, dir_ins[i], 32'h1000 + 32'(i) * 4, 1'b1, 1'b0, 1'b0, acc);
      chk("dir_valid", {31'b0, valid_a}, 32'd1);
      case (i)
        0: begin chk("addi_fmt", {29'b0, fmt_a}, 32'd1); chk("addi_imm", imm_a, 32'd0);
                 chk("addi_flags", {28'b0, u1_a, u2_a, we_a, il_a}, 32'b1000); end
        1: begin chk("sw_fmt", {29'b0, fmt_a}, 32'd2); chk("sw_rs2", {27'b0, rs2_a}, 32'd7);
                 chk("sw_imm", imm_a, 32'd8); chk("sw_f3", {29'b0, f3_a}, 32'd2); end
        2: begin chk("lbu_rd", {27'b0, rd_a}, 32'd8); chk("lbu_imm", imm_a, 32'd15); end
        3: begin chk("beq_fmt", {29'b0, fmt_a}, 32'd3); chk("beq_imm", imm_a, 32'hFFFFFFFC); end
        4: begin chk("lui_imm", imm_a, 32'h12345000); chk("lui_we", {31'b0, we_a}, 32'd1); end
        5: chk("ones_illegal", {28'b0, fmt_a, il_a}, {28'b0, 3'd7, 1'b1});
        6: chk("ld_illegal", {28'b0, fmt_a, il_a}, {28'b0, 3'd7, 1'b1});
        7: begin chk("mul_noM_illegal", {28'b0, fmt_a, il_a}, {28'b0, 3'd7, 1'b1});
                 chk("mul_M_legal", {28'b0, fmt_m, il_m}, 32'd0); end
        8: begin chk("x16_rv32e_illegal", {30'b0, il_e, we_e}, 32'b10);
                 chk("x16_rv32i_legal", {30'b0, il_a, we_a}, 32'b01); end
        default: ;
      endcase
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

    // Stream of 8 with downstream stalled on cycles 3..6.
    foreach (stream[i]) stream[i] = rand_ins();
    sent = 0;
    cyc = 0;
    while ((sent < 8 || q.size() > 0) && cyc < 40) begin
      step(sent < 8, (sent < 8) ? stream[sent % 8] : 32'd0, 32'h2000 + 32'(sent) * 4,
           !(cyc >= 3 && cyc <= 6), 1'b0, 1'b0, acc);
      if (acc) sent++;
      cyc++;
    end
    chk("stream_done", {31'b0, (sent == 8 && q.size() == 0 && cyc < 40)}, 32'd1);

    // Fill OUT and SKD, then flush, then one normal beat.
    repeat (3) step(1'b1, rand_ins(), $urandom(), 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, rand_ins(), $urandom(), 1'b0, 1'b1, 1'b0, acc);
    step(1'b1, 32'h00000013, 32'h3000, 1'b1, 1'b0, 1'b0, acc);
    chk("post_flush_valid", {31'b0, valid_a}, 32'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

    // Random traffic with occasional flush and one mid-stream reset.
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, rand_ins(), $urandom(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0, c == 200, acc);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
